// File: rtl/dwt_subband_packer.sv
// dwt_subband_packer: ping-pong row buffer that reorders (L,H)
// pairs from the 1-D lifting stage into Mallat order (lows, then highs).
module dwt_subband_packer #(
  parameter int size = 32,
  parameter int N    = 64,
  parameter int AW   = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [size-1:0] L,
  input  logic [size-1:0] H,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [size-1:0] out_data,
  output logic            out_band,
  output logic            out_last
);

  localparam int PAIRS = N / 2;
  localparam int WW    = $clog2(PAIRS);

  logic [size-1:0] lo [2][PAIRS];
  logic [size-1:0] hi [2][PAIRS];

  logic          wbank;
  logic          rbank;
  logic [1:0]    full;
  logic [1:0]    full_n;
  logic [WW-1:0] wcnt;
  logic [AW-1:0] rcnt;

  logic          wr;
  logic          rd;
  logic          wlast;
  logic          rlast;
  logic          band;
  logic [WW-1:0] raddr;

  assign in_ready  = !full[wbank];
  assign wr        = in_valid && in_ready;
  assign wlast     = wcnt == WW'(PAIRS - 1);

  assign out_valid = full[rbank];
  assign rd        = out_valid && out_ready;
  assign rlast     = rcnt == AW'(N - 1);

  // Low words occupy rcnt 0..PAIRS-1, high words the rest.
  assign band  = rcnt >= AW'(PAIRS);
  assign raddr = band ? WW'(rcnt - AW'(PAIRS))
                      : WW'(rcnt);

  assign out_band = band;
  assign out_last = out_valid && rlast;
  assign out_data = band ? hi[rbank][raddr]
                         : lo[rbank][raddr];

  // Fill and drain of different banks may land in one cycle.
  always_comb begin
    full_n = full;
    if (wr && wlast) full_n[wbank] = 1'b1;
    if (rd && rlast) full_n[rbank] = 1'b0;
  end

  // Bank pointers, counters and full flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbank <= 1'b0;
      rbank <= 1'b0;
      full  <= 2'b00;
      wcnt  <= '0;
      rcnt  <= '0;
    end else begin
      full <= full_n;
      if (wr) begin
        if (wlast) begin
          wbank <= !wbank;
          wcnt  <= '0;
        end else begin
          wcnt  <= wcnt + WW'(1);
        end
      end
      if (rd) begin
        if (rlast) begin
          rbank <= !rbank;
          rcnt  <= '0;
        end else begin
          rcnt  <= rcnt + AW'(1);
        end
      end
    end
  end

  // Coefficient storage; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr) begin
      lo[wbank][wcnt] <= L;
      hi[wbank][wcnt] <= H;
    end
  end

endmodule

// File: tb/tb_dwt_subband_packer.sv
// tb_dwt_subband_packer: directed and randomized checks of the
// Mallat-order row packer at N=8.
module tb_dwt_subband_packer;

  localparam int SZ = 32;
  localparam int NN = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [SZ-1:0] L;
  logic [SZ-1:0] H;
  logic          out_valid;
  logic          out_ready;
  logic [SZ-1:0] out_data;
  logic          out_band;
  logic          out_last;

  int vec  = 0;
  int errs = 0;

  dwt_subband_packer #(.size(SZ), .N(NN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .L         (L),
    .H         (H),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_band  (out_band),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] l,
                      input logic [31:0] h,
                      output bit ok);
    int n;
    n = 0;
    ok = 1'b0;
    in_valid = 1'b1;
    L = l;
    H = h;
    while (n < 50) begin
      if (in_ready) begin
        tick();
        ok = 1'b1;
        break;
      end
      tick();
      n++;
    end
    in_valid = 1'b0;
  endtask

  task automatic do_reset;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    L = '0;
    H = '0;
    #3;
    rst_n = 1'b0;
    tick();
    tick();
    #3;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    L = '0;
    H = '0;
    rst_n = 1'b0;
    #2;
    vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 ||
        out_band !== 1'b0 || out_last !== 1'b0) begin
      errs++;
      $display("FAIL reset: rdy=%b vld=%b band=%b last=%b want 1 0 0 0",
               in_ready, out_valid, out_band, out_last);
    end
    tick();
    tick();
    #3;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic;
    logic [31:0] e [8];
    e = '{1, 2, 3, 4, 101, 102, 103, 104};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      L = 32'(i + 1);
      H = 32'(i + 101);
      vec++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        errs++;
        $display("FAIL basic_fill[%0d]: rdy=%b vld=%b want 1 0",
                 i, in_ready, out_valid);
      end
      tick();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      vec++;
      if (out_valid !== 1'b1 || out_data !== e[k] ||
          out_band !== (k >= 4) || out_last !== (k == 7)) begin
        errs++;
        $display("FAIL basic_out[%0d]: v=%b d=%0d b=%b l=%b want 1 %0d %b %b",
                 k, out_valid, out_data, out_band, out_last,
                 e[k], k >= 4, k == 7);
      end
      tick();
    end
    vec++;
    if (out_valid !== 1'b0) begin
      errs++;
      $display("FAIL basic_idle: vld=%b want 0", out_valid);
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] e [8];
    logic [31:0] x;
    bit ok;
    e = '{99, 91, 92, 93, 199, 191, 192, 193};
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      L = 32'(10 + i);
      H = 32'(200 + i);
      vec++;
      if (in_ready !== 1'b1) begin
        errs++;
        $display("FAIL bp_fill[%0d]: rdy=%b want 1", i, in_ready);
      end
      tick();
    end
    L = 32'd99;
    H = 32'd199;
    for (int c = 0; c < 3; c++) begin
      vec++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
        errs++;
        $display("FAIL bp_hold[%0d]: rdy=%b vld=%b want 0 1",
                 c, in_ready, out_valid);
      end
      tick();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      int r;
      int j;
      if (k == 9) in_valid = 1'b0;
      r = k / 8;
      j = k % 8;
      x = (j < 4) ? 32'(10 + r * 4 + j) : 32'(200 + r * 4 + j - 4);
      vec++;
      if (out_valid !== 1'b1 || out_data !== x ||
          out_band !== (j >= 4) || out_last !== (j == 7) ||
          in_ready !== (k >= 8)) begin
        errs++;
        $display("FAIL bp_out[%0d]: v=%b d=%0d b=%b l=%b rdy=%b want 1 %0d %b %b %b",
                 k, out_valid, out_data, out_band, out_last, in_ready,
                 x, j >= 4, j == 7, k >= 8);
      end
      tick();
    end
    in_valid = 1'b0;
    vec++;
    if (out_valid !== 1'b0) begin
      errs++;
      $display("FAIL bp_idle: vld=%b want 0", out_valid);
    end
    for (int i = 0; i < 3; i++) begin
      send(32'(91 + i), 32'(191 + i), ok);
      vec++;
      if (!ok) begin
        errs++;
        $display("FAIL bp_send[%0d]: accepted=0 want 1", i);
      end
    end
    for (int k = 0; k < 8; k++) begin
      vec++;
      if (out_valid !== 1'b1 || out_data !== e[k] ||
          out_band !== (k >= 4) || out_last !== (k == 7)) begin
        errs++;
        $display("FAIL bp_held[%0d]: v=%b d=%0d b=%b l=%b want 1 %0d %b %b",
                 k, out_valid, out_data, out_band, out_last,
                 e[k], k >= 4, k == 7);
      end
      tick();
    end
  endtask

  task automatic test_stall;
    logic [31:0] e [8];
    int idx;
    bit ok;
    e = '{21, 22, 23, 24, 121, 122, 123, 124};
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(32'(21 + i), 32'(121 + i), ok);
      vec++;
      if (!ok) begin
        errs++;
        $display("FAIL stall_send[%0d]: accepted=0 want 1", i);
      end
    end
    idx = 0;
    for (int c = 0; c < 40; c++) begin
      if (idx == 8) break;
      out_ready = (c % 2) == 0;
      vec++;
      if (out_valid !== 1'b1 || out_data !== e[idx] ||
          out_band !== (idx >= 4) || out_last !== (idx == 7)) begin
        errs++;
        $display("FAIL stall[%0d]: v=%b d=%0d b=%b l=%b want 1 %0d %b %b",
                 c, out_valid, out_data, out_band, out_last,
                 e[idx], idx >= 4, idx == 7);
      end
      if (out_ready) idx++;
      tick();
    end
    out_ready = 1'b0;
    vec++;
    if (idx != 8 || out_valid !== 1'b0) begin
      errs++;
      $display("FAIL stall_end: words=%0d vld=%b want 8 0", idx, out_valid);
    end
  endtask

  task automatic test_simul;
    logic [31:0] a [8];
    logic [31:0] b [8];
    bit ok;
    a = '{31, 32, 33, 34, 131, 132, 133, 134};
    b = '{41, 42, 43, 44, 141, 142, 143, 144};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send(32'(31 + i), 32'(131 + i), ok);
      vec++;
      if (!ok) begin
        errs++;
        $display("FAIL sim_send0[%0d]: accepted=0 want 1", i);
      end
    end
    for (int i = 0; i < 3; i++) begin
      send(32'(41 + i), 32'(141 + i), ok);
      vec++;
      if (!ok) begin
        errs++;
        $display("FAIL sim_send1[%0d]: accepted=0 want 1", i);
      end
    end
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k == 7) begin
        in_valid = 1'b1;
        L = 32'd44;
        H = 32'd144;
      end
      vec++;
      if (out_valid !== 1'b1 || out_data !== a[k] ||
          out_last !== (k == 7) || in_ready !== 1'b1) begin
        errs++;
        $display("FAIL sim_b0[%0d]: v=%b d=%0d l=%b rdy=%b want 1 %0d %b 1",
                 k, out_valid, out_data, out_last, in_ready,
                 a[k], k == 7);
      end
      tick();
    end
    in_valid = 1'b0;
    vec++;
    if (out_valid !== 1'b1 || out_data !== 32'd41 ||
        out_band !== 1'b0 || in_ready !== 1'b1) begin
      errs++;
      $display("FAIL sim_swap: v=%b d=%0d b=%b rdy=%b want 1 41 0 1",
               out_valid, out_data, out_band, in_ready);
    end
    for (int k = 0; k < 8; k++) begin
      vec++;
      if (out_valid !== 1'b1 || out_data !== b[k] ||
          out_band !== (k >= 4) || out_last !== (k == 7)) begin
        errs++;
        $display("FAIL sim_b1[%0d]: v=%b d=%0d b=%b l=%b want 1 %0d %b %b",
                 k, out_valid, out_data, out_band, out_last,
                 b[k], k >= 4, k == 7);
      end
      tick();
    end
    vec++;
    if (out_valid !== 1'b0) begin
      errs++;
      $display("FAIL sim_idle: vld=%b want 0", out_valid);
    end
  endtask

  task automatic test_async_reset;
    logic [31:0] e [8];
    bit ok;
    e = '{71, 72, 73, 74, 171, 172, 173, 174};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      send(32'(51 + i), 32'(151 + i), ok);
      vec++;
      if (!ok) begin
        errs++;
        $display("FAIL ar_send[%0d]: accepted=0 want 1", i);
      end
    end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      vec++;
      if (out_valid !== 1'b1 || out_data !== 32'(51 + k)) begin
        errs++;
        $display("FAIL ar_pre[%0d]: v=%b d=%0d want 1 %0d",
                 k, out_valid, out_data, 51 + k);
      end
      tick();
    end
    #3;
    rst_n = 1'b0;
    #1;
    vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 ||
        out_last !== 1'b0 || out_band !== 1'b0) begin
      errs++;
      $display("FAIL ar_now: v=%b rdy=%b l=%b b=%b want 0 1 0 0",
               out_valid, in_ready, out_last, out_band);
    end
    out_ready = 1'b0;
    tick();
    #3;
    rst_n = 1'b1;
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(32'(71 + i), 32'(171 + i), ok);
      vec++;
      if (!ok) begin
        errs++;
        $display("FAIL ar_send2[%0d]: accepted=0 want 1", i);
      end
    end
    for (int k = 0; k < 8; k++) begin
      vec++;
      if (out_valid !== 1'b1 || out_data !== e[k] ||
          out_band !== (k >= 4) || out_last !== (k == 7)) begin
        errs++;
        $display("FAIL ar_out[%0d]: v=%b d=%0d b=%b l=%b want 1 %0d %b %b",
                 k, out_valid, out_data, out_band, out_last,
                 e[k], k >= 4, k == 7);
      end
      tick();
    end
    vec++;
    if (out_valid !== 1'b0) begin
      errs++;
      $display("FAIL ar_idle: vld=%b want 0 (stale row)", out_valid);
    end
  endtask

  task automatic test_random;
    logic [31:0] qd [$];
    bit          qb [$];
    bit          ql [$];
    logic [31:0] rl [4];
    logic [31:0] rh [4];
    logic [31:0] ed;
    bit          eb;
    bit          el;
    bit          pend;
    int          sent;
    int          pc;
    int          got;
    int          cyc;
    int          r;
    do_reset();
    pend = 1'b0;
    sent = 0;
    pc   = 0;
    got  = 0;
    cyc  = 0;
    while (got < 800 && cyc < 20000) begin
      if (!pend && sent < 400 && $urandom_range(0, 3) != 0) begin
        pend = 1'b1;
        r = $urandom_range(0, 7);
        L = (r == 0) ? 32'h8000_0000 :
            (r == 1) ? 32'hFFFF_FFFF : 32'($urandom);
        r = $urandom_range(0, 7);
        H = (r == 0) ? 32'hFFFF_FFFF :
            (r == 1) ? 32'h8000_0000 : 32'($urandom);
        if (sent == 0) begin
          L = 32'h8000_0000;
          H = 32'hFFFF_FFFF;
        end
      end
      in_valid  = pend;
      out_ready = $urandom_range(0, 2) != 0;
      if (out_valid && out_ready) begin
        vec++;
        if (qd.size() == 0) begin
          errs++;
          $display("FAIL rnd_extra: d=%h with empty scoreboard", out_data);
        end else begin
          ed = qd.pop_front();
          eb = qb.pop_front();
          el = ql.pop_front();
          if (out_data !== ed || out_band !== eb || out_last !== el) begin
            errs++;
            $display("FAIL rnd[%0d]: d=%h b=%b l=%b want %h %b %b",
                     got, out_data, out_band, out_last, ed, eb, el);
          end
        end
        got++;
      end
      if (pend && in_ready) begin
        rl[pc] = L;
        rh[pc] = H;
        pc++;
        sent++;
        pend = 1'b0;
        if (pc == 4) begin
          for (int i = 0; i < 4; i++) begin
            qd.push_back(rl[i]);
            qb.push_back(1'b0);
            ql.push_back(1'b0);
          end
          for (int i = 0; i < 4; i++) begin
            qd.push_back(rh[i]);
            qb.push_back(1'b1);
            ql.push_back(i == 3);
          end
          pc = 0;
        end
      end
      tick();
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    vec++;
    if (got != 800 || qd.size() != 0) begin
      errs++;
      $display("FAIL rnd_count: words=%0d left=%0d want 800 0",
               got, qd.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_stall();
    test_simul();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/dwt_subband_packer.md
Name: dwt_subband_packer

Overview:
- Downstream of the 1-D 9/7 lifting transform. Consumes one (L,H) coefficient pair per accepted cycle and buffers a full row.
- Re-emits each row in Mallat order: all N/2 low-band words, then all N/2 high-band words, as a single-word valid/ready stream.
- Feeds the column (second-dimension) pass.
- Ping-pong banks let one row fill while the previous row drains.

Parameters:
- size, 32, coefficient width in bits; matches the transform's L/H width.
- N, 64, samples per row; even, N >= 4. PAIRS = N/2 coefficient pairs per row.
- AW, $clog2(N), read-counter width. The write counter is $clog2(PAIRS) bits.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  L/H pair valid
- in_ready  output  1  packer can accept a pair this cycle
- L  input  size  low-band coefficient from transform
- H  input  size  high-band coefficient from transform
- out_valid  output  1  out_data valid
- out_ready  input  1  downstream accepts out_data
- out_data  output  size  coefficient word
- out_band  output  1  0 = low band word, 1 = high band word
- out_last  output  1  final word of a row (high band index PAIRS-1)

Behaviour:
- Storage: two banks (0,1). Each bank has lo[PAIRS] and hi[PAIRS] of size bits.
- State registers: wbank, rbank, full[1:0], wcnt (0..PAIRS-1), rcnt (0..N-1).
- Reset (async, rst_n low): wbank=0, rbank=0, full=2'b00, wcnt=0, rcnt=0.
  - Outputs during and after reset: in_ready=1, out_valid=0, out_band=0, out_last=0.
  - out_data is don't-care while out_valid=0.
  - Memory contents are not reset.
  - Reset mid-row discards all partial and full rows. The first pair after reset goes to bank 0 index 0.
- Write side:
  - in_ready = !full[wbank], combinational from registers.
  - A pair is accepted when in_valid && in_ready: lo[wbank][wcnt] <= L, hi[wbank][wcnt] <= H.
  - If wcnt == PAIRS-1 on an accepted pair: full[wbank] <= 1, wbank toggles, wcnt <= 0. Otherwise wcnt increments.
  - in_valid while in_ready=0: nothing is written and the pair is not consumed. The upstream holds it.
- Read side:
  - out_valid = full[rbank].
  - rcnt < PAIRS: out_data = lo[rbank][rcnt], out_band = 0.
  - rcnt >= PAIRS: out_data = hi[rbank][rcnt-PAIRS], out_band = 1.
  - out_last = out_valid && (rcnt == N-1).
  - Output is combinational from registers and memory; there is no output register.
  - A word transfers when out_valid && out_ready. On transfer, rcnt increments.
  - On the transfer with rcnt == N-1: full[rbank] <= 0, rbank toggles, rcnt <= 0.
  - With out_valid=1 and out_ready=0, out_data, out_band and out_last hold stable.
- Simultaneous events:
  - A write completing a bank and a read freeing the other bank in the same cycle both take effect.
  - They never target the same bank: writes need !full and reads need full.
  - A bank freed this cycle is writable next cycle. Its in_ready rises the cycle after the freeing transfer.
- Latency:
  - A bank's last pair accepted at cycle t gives out_valid=1 at t+1, if that bank is the next to drain.
  - Each row drains in N cycles minimum.
- Throughput and capacity:
  - Input can run at up to 1 pair/cycle; output runs at 1 word/cycle.
  - Sustained input therefore back-pressures via in_ready.
  - At most two complete rows are buffered. in_ready=0 exactly when both banks are full.
- Arithmetic: no data modification. Words pass bit-exact, with no sign handling.

Test Plan:
- Reset, then N=8 and PAIRS=4, out_ready=1. Send pairs (L,H) = (1,101),(2,102),(3,103),(4,104) on consecutive cycles.
  - Expected: out_valid rises the cycle after the 4th pair.
  - Expected out_data sequence 1,2,3,4,101,102,103,104 with out_band 0,0,0,0,1,1,1,1.
  - out_last=1 only on 104.
- out_ready=0, send 8 pairs (two rows) continuously.
  - Expected: in_ready drops after the 8th pair and a 9th pair is held, not written.
  - Then raise out_ready: row 1 drains, then row 2.
  - in_ready returns the cycle after row 1's out_last transfer, and the held 9th pair lands at bank 0 index 0.
- Toggle out_ready with a 1-0-1-0 pattern mid-row.
  - Expected: out_data and out_band stable while stalled; no word duplicated or skipped.
- Fill bank 1 with its last pair on the same cycle that bank 0's last word (out_last) transfers.
  - Expected: next cycle full=2'b10, rbank=1, out_valid=1, and out_data is bank 1 lo[0].
- Assert rst_n=0 asynchronously mid-drain (rcnt=3) with one bank pending.
  - Expected: out_valid=0 and in_ready=1 immediately.
  - Expected: a following row of 4 pairs is output cleanly with no stale words.
- Random L/H values at size=32 including 32'h8000_0000 and 32'hFFFF_FFFF.
  - Expected: a bit-exact match against a scoreboard in Mallat order over 100 rows with random in_valid and out_ready.
